// File: rtl/bht_assoc_lru.sv
// Fully-associative branch history table with per-entry target storage.
// Fetch looks up combinationally by pc_r; execute writes outcomes via op.
// Replacement is true LRU over per-entry age counters (a permutation of
// 0..NITEM-1, 0 = most recently touched).

// Per-entry tag compare for the read and write ports.
module bht_assoc_lru_entry #(
  parameter int ADDR_NBIT = 10
) (
  input  logic                 vld,
  input  logic [ADDR_NBIT-1:0] pc,
  input  logic [ADDR_NBIT-1:0] pc_r,
  input  logic [ADDR_NBIT-1:0] pc_w,
  output logic                 match_r,
  output logic                 match_w
);
  assign match_r = vld && (pc == pc_r);
  assign match_w = vld && (pc == pc_w);
endmodule

module bht_assoc_lru #(
  parameter int ADDR_NBIT = 10,
  parameter int IDX_NBIT  = 3,
  parameter int CNT_NBIT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [2:0]           op,
  input  logic [ADDR_NBIT-1:0] pc_r,
  input  logic [ADDR_NBIT-1:0] pc_w,
  input  logic [ADDR_NBIT-1:0] dst_w,
  output logic                 hit_r,
  output logic                 take_r,
  output logic [ADDR_NBIT-1:0] dst_r
);
  localparam int NITEM = 2 ** IDX_NBIT;

  localparam logic [2:0] OP_SET = 3'd1;
  localparam logic [2:0] OP_DEC = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_INV = 3'd4;

  localparam logic [CNT_NBIT-1:0] CNT_MAX = {CNT_NBIT{1'b1}};
  localparam logic [CNT_NBIT-1:0] CNT_MID = CNT_NBIT'(1) << (CNT_NBIT - 1);
  localparam logic [IDX_NBIT-1:0] AGE_OLD = {IDX_NBIT{1'b1}};

  logic [NITEM-1:0]                vld_q;
  logic [NITEM-1:0][ADDR_NBIT-1:0] pc_q;
  logic [NITEM-1:0][ADDR_NBIT-1:0] dst_q;
  logic [NITEM-1:0][CNT_NBIT-1:0]  cnt_q;
  logic [NITEM-1:0][IDX_NBIT-1:0]  age_q;

  logic [NITEM-1:0] match_r, match_w;

  for (genvar g = 0; g < NITEM; g++) begin : g_ent
    bht_assoc_lru_entry #(.ADDR_NBIT(ADDR_NBIT)) u_ent (
      .vld     (vld_q[g]),
      .pc      (pc_q[g]),
      .pc_r    (pc_r),
      .pc_w    (pc_w),
      .match_r (match_r[g]),
      .match_w (match_w[g])
    );
  end

  // Read mux: at most one entry matches, so an OR of masked fields suffices.
  always_comb begin
    dst_r  = '0;
    take_r = 1'b0;
    for (int i = 0; i < NITEM; i++) begin
      if (match_r[i]) begin
        dst_r  = dst_r | dst_q[i];
        take_r = take_r | cnt_q[i][CNT_NBIT-1];
      end
    end
  end
  assign hit_r = |match_r;

  logic                 hit_w;
  logic [IDX_NBIT-1:0]  hit_idx, victim, tgt;
  logic [IDX_NBIT-1:0]  tgt_age;
  logic [CNT_NBIT-1:0]  tgt_cnt, cnt_nxt;
  logic                 do_write, do_inv;

  // Victim: lowest invalid entry, else the oldest; descending scan so the
  // lowest invalid index overrides the age pick.
  always_comb begin
    hit_idx = '0;
    victim  = '0;
    for (int i = 0; i < NITEM; i++) begin
      if (match_w[i])         hit_idx = IDX_NBIT'(i);
      if (age_q[i] == AGE_OLD) victim = IDX_NBIT'(i);
    end
    for (int i = NITEM - 1; i >= 0; i--) begin
      if (!vld_q[i]) victim = IDX_NBIT'(i);
    end
  end

  assign hit_w    = |match_w;
  assign tgt      = hit_w ? hit_idx : victim;
  assign tgt_age  = age_q[tgt];
  assign tgt_cnt  = cnt_q[tgt];
  assign do_write = !flush && (op == OP_SET || op == OP_DEC || op == OP_INC);
  assign do_inv   = !flush && (op == OP_INV) && hit_w;

  // New counter value for the target entry.
  always_comb begin
    cnt_nxt = CNT_MAX;
    case (op)
      OP_INC:  cnt_nxt = !hit_w ? CNT_MID
                       : (tgt_cnt == CNT_MAX) ? CNT_MAX : tgt_cnt + 1'b1;
      OP_DEC:  cnt_nxt = !hit_w ? CNT_MID - 1'b1
                       : (tgt_cnt == '0) ? '0 : tgt_cnt - 1'b1;
      default: cnt_nxt = CNT_MAX;
    endcase
  end

  // Valid bits and LRU ages: reset-held control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < NITEM; i++) age_q[i] <= IDX_NBIT'(i);
    end else if (flush) begin
      vld_q <= '0;
    end else if (do_inv) begin
      vld_q[tgt] <= 1'b0;
    end else if (do_write) begin
      vld_q[tgt] <= 1'b1;
      for (int i = 0; i < NITEM; i++) begin
        if (IDX_NBIT'(i) == tgt)     age_q[i] <= '0;
        else if (age_q[i] < tgt_age) age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  // Payload fields carry no reset; they are meaningless while vld is low.
  always_ff @(posedge clk) begin
    if (rst_n && do_write) begin
      pc_q[tgt]  <= pc_w;
      dst_q[tgt] <= dst_w;
      cnt_q[tgt] <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_bht_assoc_lru.sv
// Directed bench for bht_assoc_lru (ADDR_NBIT=10, IDX_NBIT=3, CNT_NBIT=2).
module tb_bht_assoc_lru;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [9:0] pc_r = '0, pc_w = '0, dst_w = '0;
  logic       hit_r, take_r;
  logic [9:0] dst_r;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] NOP = 3'd0, SET = 3'd1, DEC = 3'd2, INC = 3'd3, INV = 3'd4;

  bht_assoc_lru #(.ADDR_NBIT(10), .IDX_NBIT(3), .CNT_NBIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .op(op),
    .pc_r(pc_r), .pc_w(pc_w), .dst_w(dst_w),
    .hit_r(hit_r), .take_r(take_r), .dst_r(dst_r)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] o, input logic [9:0] pc, input logic [9:0] d);
    op = o; pc_w = pc; dst_w = d;
    @(posedge clk); #1;
    op = NOP;
  endtask

  task automatic chk(input string tag, input logic [9:0] pc,
                     input logic eh, input logic et, input logic [9:0] ed);
    pc_r = pc; #1;
    checks++;
    assert (hit_r === eh) else begin
      failures++; $error("FAIL %s hit_r got=%0b exp=%0b", tag, hit_r, eh);
    end
    checks++;
    assert (take_r === et) else begin
      failures++; $error("FAIL %s take_r got=%0b exp=%0b", tag, take_r, et);
    end
    checks++;
    assert (dst_r === ed) else begin
      failures++; $error("FAIL %s dst_r got=%h exp=%h", tag, dst_r, ed);
    end
  endtask

  initial begin
    // reset state
    #2 chk("rst", 10'h040, 0, 0, 10'h000);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: allocate on INC miss, cnt=MID=2
    do_op(INC, 10'h040, 10'h100);
    chk("alloc", 10'h040, 1, 1, 10'h100);
    chk("miss",  10'h044, 0, 0, 10'h000);
    do_op(3'd5, 10'h044, 10'h111);
    chk("undef_op", 10'h044, 0, 0, 10'h000);

    // 2: saturation 2->3->3->2->1, then back up to 3 and refresh target
    do_op(INC, 10'h040, 10'h100);
    do_op(INC, 10'h040, 10'h100);
    do_op(DEC, 10'h040, 10'h100);
    chk("dec_to2", 10'h040, 1, 1, 10'h100);
    do_op(DEC, 10'h040, 10'h100);
    chk("dec_to1", 10'h040, 1, 0, 10'h100);
    do_op(INC, 10'h040, 10'h100);
    do_op(INC, 10'h040, 10'h100);
    do_op(INC, 10'h040, 10'h180);
    chk("sat_dst", 10'h040, 1, 1, 10'h180);

    // 3: DEC miss -> cnt=1; floor at 0; SET -> 3
    do_op(DEC, 10'h050, 10'h200);
    chk("dec_miss", 10'h050, 1, 0, 10'h200);
    do_op(DEC, 10'h050, 10'h200);
    do_op(DEC, 10'h050, 10'h200);
    do_op(INC, 10'h050, 10'h200);
    chk("floor0", 10'h050, 1, 0, 10'h200);
    do_op(INC, 10'h050, 10'h204);
    chk("up_to2", 10'h050, 1, 1, 10'h204);
    do_op(SET, 10'h050, 10'h210);
    chk("set", 10'h050, 1, 1, 10'h210);
    chk("other_kept", 10'h040, 1, 1, 10'h180);

    // 4: LRU eviction from a clean table
    rst_n = 1'b0; #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst2", 10'h040, 0, 0, 10'h000);
    for (int i = 0; i < 8; i++) do_op(INC, 10'(i), 10'h300 + 10'(i));
    do_op(INC, 10'h000, 10'h300);
    do_op(INC, 10'h008, 10'h308);
    chk("evicted", 10'h001, 0, 0, 10'h000);
    chk("touched", 10'h000, 1, 1, 10'h300);
    chk("new",     10'h008, 1, 1, 10'h308);
    chk("kept2",   10'h002, 1, 1, 10'h302);

    // 5: INV frees a slot; next alloc uses it without eviction
    do_op(INV, 10'h003, 10'h000);
    chk("inv", 10'h003, 0, 0, 10'h000);
    do_op(INV, 10'h0FF, 10'h000);
    chk("inv_miss", 10'h002, 1, 1, 10'h302);
    do_op(INC, 10'h009, 10'h309);
    chk("fill_free", 10'h009, 1, 1, 10'h309);
    chk("no_evict2", 10'h002, 1, 1, 10'h302);
    for (int i = 4; i < 8; i++) chk("no_evict", 10'(i), 1, 1, 10'h300 + 10'(i));
    chk("no_evict8", 10'h008, 1, 1, 10'h308);

    flush = 1'b1;
    do_op(SET, 10'h00A, 10'h30A);
    flush = 1'b0;
    chk("flush_set", 10'h00A, 0, 0, 10'h000);
    chk("flush0",    10'h000, 0, 0, 10'h000);
    chk("flush9",    10'h009, 0, 0, 10'h000);

    // 6: async reset mid-cycle discards an in-flight INC
    do_op(INC, 10'h030, 10'h400);
    chk("pre_rst", 10'h030, 1, 1, 10'h400);
    @(posedge clk); #1;
    op = INC; pc_w = 10'h031; dst_w = 10'h401;
    #1 rst_n = 1'b0;
    chk("async_rst", 10'h030, 0, 0, 10'h000);
    @(posedge clk); #3;
    rst_n = 1'b1;
    op = INC; pc_w = 10'h020; dst_w = 10'h420;
    @(posedge clk); #1;
    op = NOP;
    chk("discarded", 10'h031, 0, 0, 10'h000);
    chk("post_rst",  10'h020, 1, 1, 10'h420);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bht_assoc_lru.md
Name: bht_assoc_lru

Overview:
Parametrised fully-associative branch history table with target storage, the successor to the fixed 8-entry, 2-bit BHT in the fetch stage. Fetch does a combinational lookup by PC for a predicted target and direction. Execute writes back branch outcomes. Adds configurable depth, address width and counter width, explicit per-entry invalidate, a whole-table flush, a hit output, and target refresh on saturated hits. Replacement is true LRU over age counters.

Parameters:
ADDR_NBIT, 10, width of pc_r, pc_w, dst_w and dst_r.
IDX_NBIT, 3, log2 of entry count; NITEM = 2**IDX_NBIT; legal range 1..5.
CNT_NBIT, 2, saturating history counter width; legal range 1..4.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous invalidate of all entries; priority over op.
op  in  3  update op: 0 NOP, 1 SET, 2 DEC, 3 INC, 4 INV; 5..7 act as NOP.
pc_r  in  ADDR_NBIT  lookup PC (fetch).
pc_w  in  ADDR_NBIT  update PC (execute).
dst_w  in  ADDR_NBIT  branch target to record.
hit_r  out  1  pc_r matches a valid entry; combinational.
take_r  out  1  hit_r AND counter MSB of the matching entry; combinational.
dst_r  out  ADDR_NBIT  stored target of the matching entry, 0 on miss; combinational.

Behaviour:
- State per entry: vld, pc, dst, cnt[CNT_NBIT-1:0], age[IDX_NBIT-1:0].
- Reset (async): all vld=0 and age[i]=i. pc/dst/cnt are not reset. Outputs: hit_r=0, take_r=0, dst_r=0.
- Read path is purely combinational on current state. A write at edge N is visible to pc_r lookups after edge N; there is no same-cycle bypass.
- At most one entry matches a given PC (the write policy guarantees it). hit_w means pc_w matches a valid entry.
- Write target: the matching entry on hit_w. On a miss, the victim is the lowest-index invalid entry; if all entries are valid, it is the entry with age == NITEM-1.
- Let MAX = 2**CNT_NBIT-1 and MID = 2**(CNT_NBIT-1).
- SET: write vld=1, pc, dst, cnt=MAX. Touch LRU.
- INC, miss: allocate the victim with cnt=MID.
- INC, hit: cnt+1, saturating at MAX. dst is always rewritten. Touch LRU.
- DEC, miss: allocate the victim with cnt=MID-1.
- DEC, hit: cnt-1, saturating at 0. dst is always rewritten. Touch LRU.
- INV: on hit_w, clear vld of the matching entry. Ages are unchanged and there is no LRU touch. On a miss, no effect.
- NOP and undefined ops: no state change.
- LRU touch of entry t with old age a: age[t]<=0; every entry with age<a gets age+1; others unchanged. Ages stay a permutation of 0..NITEM-1 at all times.
- flush=1: all vld<=0 at the edge; ages are unchanged; op is ignored that cycle.
- CNT_NBIT=1: MID=1 and MID-1=0; saturation rules still apply.
- Reset asserted mid-operation discards any in-flight update. The first edge after release behaves as if from reset state.
- Single write port. Table updates take effect only at rising clk; there are no multi-cycle operations.

Test Plan:
1. Reset, IDX_NBIT=3, CNT_NBIT=2: INC pc_w=0x040 dst_w=0x100 -> next cycle pc_r=0x040 gives hit_r=1, take_r=1, dst_r=0x100; entry 0 has cnt=2; pc_r=0x044 gives hit_r=0, dst_r=0.
2. Saturation: INC on 0x040 three times, then DEC once -> cnt goes 2,3,3,2 and take_r stays 1. A further DEC gives cnt=1, take_r=0. INC at cnt=3 with dst_w=0x180 -> dst_r=0x180.
3. Miss allocation: DEC on a new PC 0x050 -> cnt=1, take_r=0, hit_r=1. SET on 0x050 -> cnt=3, take_r=1.
4. LRU eviction: INC 8 distinct PCs 0x000..0x007, touch 0x000 again, then INC 0x008 -> 0x001 is evicted (hit_r=0); 0x000 and 0x008 both hit.
5. INV and flush: INV 0x003 -> hit_r=0 for 0x003. A following INC 0x009 lands in the freed slot with no eviction. Flush with simultaneous SET 0x00A -> all hit_r=0 and 0x00A is not present.
6. Async reset: assert rst_n=0 mid-cycle during an INC -> hit_r=0 immediately. After release, INC 0x020 allocates entry 0.
